// File: rtl/csi2_raw10_depacker.sv
// csi2_raw10_depacker: turns RAW10 long-packet payload beats into 4-pixel
// (40-bit) groups with start-of-frame / end-of-line markers, tracks FS/FE
// framing, drops foreign long packets and flags malformed lines.
module csi2_raw10_depacker #(
  parameter logic [5:0] RAW10_DT = 6'h2B,
  parameter logic [5:0] FS_DT    = 6'h00,
  parameter logic [5:0] FE_DT    = 6'h01
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        short_pkt_valid_i,
  input  logic [5:0]  short_pkt_data_type_i,
  input  logic        long_pkt_header_valid_i,
  input  logic [5:0]  long_pkt_data_type_i,
  input  logic [15:0] long_pkt_word_cnt_i,
  input  logic [31:0] long_pkt_payload_i,
  input  logic        long_pkt_payload_valid_i,
  input  logic [3:0]  long_pkt_payload_be_i,
  input  logic        long_pkt_eop_i,
  output logic [39:0] pix_tdata_o,
  output logic        pix_tvalid_o,
  output logic        pix_tuser_o,
  output logic        pix_tlast_o,
  output logic [15:0] line_cnt_o,
  output logic        line_err_o,
  output logic        dropped_pkt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] buf_q, buf_d;           // byte buffer, oldest byte in [7:0]
  logic [3:0]  cnt_q, cnt_d;           // valid bytes held in buf_q
  logic        sof_pending_q, sof_pending_d;
  logic [39:0] pix_tdata_q, pix_tdata_d;
  logic        pix_tvalid_q, pix_tvalid_d;
  logic        pix_tuser_q, pix_tuser_d;
  logic        pix_tlast_q, pix_tlast_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        line_err_q, line_err_d;
  logic        dropped_pkt_q, dropped_pkt_d;

  logic [31:0] payload_masked;
  logic [2:0]  beat_bytes;
  logic [63:0] merged;
  logic [3:0]  total;
  logic        beat_in_line;
  logic        eop_in_line;
  logic        group_ready;
  logic [3:0]  rem_cnt;
  logic [63:0] rem_buf;
  logic [39:0] group_pix;
  logic        hdr_len_bad;

  // Zero disabled byte lanes so they never pollute the buffer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign payload_masked[8*gi +: 8] =
      long_pkt_payload_be_i[gi] ? long_pkt_payload_i[8*gi +: 8] : 8'h00;
  end

  assign beat_bytes = {2'b00, long_pkt_payload_be_i[0]} + {2'b00, long_pkt_payload_be_i[1]}
                    + {2'b00, long_pkt_payload_be_i[2]} + {2'b00, long_pkt_payload_be_i[3]};

  // New bytes land directly above the bytes already buffered (cnt_q <= 4 here).
  assign merged       = buf_q | ({32'h0, payload_masked} << {cnt_q, 3'b000});
  assign total        = cnt_q + {1'b0, beat_bytes};
  assign beat_in_line = (state_q == ST_LINE) && long_pkt_payload_valid_i;
  assign eop_in_line  = beat_in_line && long_pkt_eop_i;
  assign group_ready  = beat_in_line && (total >= 4'd5);
  assign rem_cnt      = group_ready ? (total - 4'd5) : total;
  assign rem_buf      = group_ready ? (merged >> 40) : merged;

  // Pixel i = {byte i, the matching 2-bit slice of the shared fifth byte}.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pix
    assign group_pix[10*gi +: 10] = {merged[8*gi +: 8], merged[32 + 2*gi +: 2]};
  end

  assign hdr_len_bad = (long_pkt_word_cnt_i == 16'd0) ||
                       ((long_pkt_word_cnt_i % 16'd5) != 16'd0);

  // Next-state: payload is handled first, then headers, then short packets,
  // so a short packet sharing a cycle with the eop beat sees the line finish.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    sof_pending_d = sof_pending_q;
    pix_tdata_d   = pix_tdata_q;
    pix_tvalid_d  = 1'b0;
    pix_tuser_d   = 1'b0;
    pix_tlast_d   = 1'b0;
    line_cnt_d    = line_cnt_q;
    line_err_d    = 1'b0;
    dropped_pkt_d = 1'b0;

    if (beat_in_line) begin
      if (group_ready) begin
        pix_tvalid_d  = 1'b1;
        pix_tdata_d   = group_pix;
        pix_tuser_d   = sof_pending_q;
        sof_pending_d = 1'b0;
      end
      if (long_pkt_eop_i) begin
        state_d = ST_FRAME;
        buf_d   = 64'h0;
        cnt_d   = 4'd0;
        if (group_ready && (rem_cnt == 4'd0)) begin
          pix_tlast_d = 1'b1;
          line_cnt_d  = line_cnt_q + 16'd1;
        end else begin
          line_err_d = 1'b1;
        end
      end else begin
        buf_d = rem_buf;
        cnt_d = rem_cnt;
      end
    end

    if (long_pkt_header_valid_i) begin
      if ((state_q == ST_FRAME) && (long_pkt_data_type_i == RAW10_DT)) begin
        if (hdr_len_bad) begin
          line_err_d = 1'b1;
        end else begin
          state_d = ST_LINE;
          buf_d   = 64'h0;
          cnt_d   = 4'd0;
        end
      end else begin
        dropped_pkt_d = 1'b1;
      end
    end

    if (short_pkt_valid_i) begin
      if (short_pkt_data_type_i == FS_DT) begin
        // A frame start that cuts an unfinished line truncates it.
        if ((state_q == ST_LINE) && !eop_in_line) begin
          line_err_d = 1'b1;
        end
        state_d       = ST_FRAME;
        sof_pending_d = 1'b1;
        line_cnt_d    = 16'd0;
        buf_d         = 64'h0;
        cnt_d         = 4'd0;
      end else if ((short_pkt_data_type_i == FE_DT) && (state_q != ST_IDLE)) begin
        if ((state_q == ST_LINE) && !eop_in_line) begin
          line_err_d = 1'b1;
        end
        state_d = ST_IDLE;
        buf_d   = 64'h0;
        cnt_d   = 4'd0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      buf_q         <= 64'h0;
      cnt_q         <= 4'd0;
      sof_pending_q <= 1'b0;
      pix_tdata_q   <= 40'h0;
      pix_tvalid_q  <= 1'b0;
      pix_tuser_q   <= 1'b0;
      pix_tlast_q   <= 1'b0;
      line_cnt_q    <= 16'd0;
      line_err_q    <= 1'b0;
      dropped_pkt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      sof_pending_q <= sof_pending_d;
      pix_tdata_q   <= pix_tdata_d;
      pix_tvalid_q  <= pix_tvalid_d;
      pix_tuser_q   <= pix_tuser_d;
      pix_tlast_q   <= pix_tlast_d;
      line_cnt_q    <= line_cnt_d;
      line_err_q    <= line_err_d;
      dropped_pkt_q <= dropped_pkt_d;
    end
  end

  assign pix_tdata_o   = pix_tdata_q;
  assign pix_tvalid_o  = pix_tvalid_q;
  assign pix_tuser_o   = pix_tuser_q;
  assign pix_tlast_o   = pix_tlast_q;
  assign line_cnt_o    = line_cnt_q;
  assign line_err_o    = line_err_q;
  assign dropped_pkt_o = dropped_pkt_q;

endmodule

// File: tb/tb_csi2_raw10_depacker.sv
// Directed bench for csi2_raw10_depacker: framing, unpacking, drops, errors.
module tb_csi2_raw10_depacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        short_valid;
  logic [5:0]  short_dt;
  logic        hdr_valid;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [31:0] payload;
  logic        payload_valid;
  logic [3:0]  payload_be;
  logic        eop;
  logic [39:0] pix_tdata;
  logic        pix_tvalid;
  logic        pix_tuser;
  logic        pix_tlast;
  logic [15:0] line_cnt;
  logic        line_err;
  logic        dropped_pkt;

  always #5 clk = ~clk;

  csi2_raw10_depacker dut (
    .clk_i                    (clk),
    .rst_n_i                  (rst_n),
    .short_pkt_valid_i        (short_valid),
    .short_pkt_data_type_i    (short_dt),
    .long_pkt_header_valid_i  (hdr_valid),
    .long_pkt_data_type_i     (hdr_dt),
    .long_pkt_word_cnt_i      (hdr_wc),
    .long_pkt_payload_i       (payload),
    .long_pkt_payload_valid_i (payload_valid),
    .long_pkt_payload_be_i    (payload_be),
    .long_pkt_eop_i           (eop),
    .pix_tdata_o              (pix_tdata),
    .pix_tvalid_o             (pix_tvalid),
    .pix_tuser_o              (pix_tuser),
    .pix_tlast_o              (pix_tlast),
    .line_cnt_o               (line_cnt),
    .line_err_o               (line_err),
    .dropped_pkt_o            (dropped_pkt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge away from register updates.
  logic [39:0] grp_data[$];
  logic        grp_user[$];
  logic        grp_last[$];
  int          grp_cyc[$];
  int          err_pulses = 0;
  int          drop_pulses = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (pix_tvalid === 1'b1) begin
      grp_data.push_back(pix_tdata);
      grp_user.push_back(pix_tuser);
      grp_last.push_back(pix_tlast);
      grp_cyc.push_back(cyc);
    end
    if (line_err === 1'b1) err_pulses++;
    if (dropped_pkt === 1'b1) drop_pulses++;
  end

  int g_base, e_base, d_base;

  task automatic mark();
    g_base = grp_data.size();
    e_base = err_pulses;
    d_base = drop_pulses;
  endtask

  function automatic logic [63:0] n_groups();
    return 64'(grp_data.size() - g_base);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_short(input logic [5:0] dt);
    short_valid = 1'b1;
    short_dt    = dt;
    @(negedge clk);
    short_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [5:0] dt, input logic [15:0] wc);
    hdr_valid = 1'b1;
    hdr_dt    = dt;
    hdr_wc    = wc;
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] be, input logic last);
    payload       = d;
    payload_be    = be;
    eop           = last;
    payload_valid = 1'b1;
    @(negedge clk);
    payload_valid = 1'b0;
    eop           = 1'b0;
  endtask

  // Hand-computed groups: {P3,P2,P1,P0}, Pi = {byte i, 2-bit slice of byte 4}.
  localparam logic [39:0] G_SPEC = 40'h03_0080_1400;  // bytes 00 01 02 03 04
  localparam logic [39:0] G1 = {8'h44, 2'b11, 8'h33, 2'b10, 8'h22, 2'b01, 8'h11, 2'b00};
  localparam logic [39:0] G2 = {8'h88, 2'b00, 8'h77, 2'b01, 8'h66, 2'b10, 8'h55, 2'b11};
  localparam logic [39:0] G3 = {8'hCC, 2'b11, 8'hBB, 2'b10, 8'hAA, 2'b01, 8'h99, 2'b00};
  localparam logic [39:0] G4 = {8'h00, 2'b00, 8'hFF, 2'b01, 8'hEE, 2'b10, 8'hDD, 2'b11};
  localparam logic [39:0] G5 = {8'h04, 2'b00, 8'h03, 2'b00, 8'h02, 2'b01, 8'h01, 2'b01};

  initial begin
    rst_n = 1'b0; short_valid = 1'b0; short_dt = 6'h0; hdr_valid = 1'b0;
    hdr_dt = 6'h0; hdr_wc = 16'h0; payload = 32'h0; payload_valid = 1'b0;
    payload_be = 4'h0; eop = 1'b0;

    // Reset state
    idle(3);
    check_val("rst_tdata", 64'(pix_tdata), 64'h0);
    check_val("rst_tvalid", 64'(pix_tvalid), 64'h0);
    check_val("rst_tuser", 64'(pix_tuser), 64'h0);
    check_val("rst_tlast", 64'(pix_tlast), 64'h0);
    check_val("rst_line_cnt", 64'(line_cnt), 64'h0);
    check_val("rst_line_err", 64'(line_err), 64'h0);
    check_val("rst_dropped", 64'(dropped_pkt), 64'h0);
    rst_n = 1'b1;
    idle(1);

    // Single-group line right after FS
    mark();
    send_short(6'h00);
    send_hdr(6'h2B, 16'd5);
    send_beat(32'h03020100, 4'b1111, 1'b0);
    send_beat(32'h00000004, 4'b0001, 1'b1);
    idle(2);
    check_val("l1_groups", n_groups(), 64'd1);
    check_val("l1_tdata", 64'(grp_data[g_base]), 64'(G_SPEC));
    check_val("l1_tuser", 64'(grp_user[g_base]), 64'd1);
    check_val("l1_tlast", 64'(grp_last[g_base]), 64'd1);
    check_val("l1_line_cnt", 64'(line_cnt), 64'd1);
    check_val("l1_err", 64'(err_pulses - e_base), 64'd0);

    // Four-group line, back-to-back beats
    mark();
    send_hdr(6'h2B, 16'd20);
    send_beat(32'h44332211, 4'b1111, 1'b0);
    send_beat(32'h776655E4, 4'b1111, 1'b0);
    send_beat(32'hAA991B88, 4'b1111, 1'b0);
    send_beat(32'hDDE4CCBB, 4'b1111, 1'b0);
    send_beat(32'h1B00FFEE, 4'b1111, 1'b1);
    idle(2);
    check_val("l2_groups", n_groups(), 64'd4);
    check_val("l2_g0", 64'(grp_data[g_base]), 64'(G1));
    check_val("l2_g1", 64'(grp_data[g_base + 1]), 64'(G2));
    check_val("l2_g2", 64'(grp_data[g_base + 2]), 64'(G3));
    check_val("l2_g3", 64'(grp_data[g_base + 3]), 64'(G4));
    check_val("l2_tuser", 64'({grp_user[g_base + 3], grp_user[g_base + 2], grp_user[g_base + 1], grp_user[g_base]}), 64'h0);
    check_val("l2_tlast", 64'({grp_last[g_base + 3], grp_last[g_base + 2], grp_last[g_base + 1], grp_last[g_base]}), 64'b1000);
    check_val("l2_spacing", 64'(grp_cyc[g_base + 3] - grp_cyc[g_base]), 64'd3);
    check_val("l2_line_cnt", 64'(line_cnt), 64'd2);

    // FE -> IDLE: a RAW10 header is now dropped and its payload ignored
    send_short(6'h01);
    mark();
    send_hdr(6'h2B, 16'd5);
    send_beat(32'h03020100, 4'b1111, 1'b0);
    send_beat(32'h00000004, 4'b0001, 1'b1);
    idle(2);
    check_val("idle_drop", 64'(drop_pulses - d_base), 64'd1);
    check_val("idle_groups", n_groups(), 64'd0);
    check_val("fe_line_cnt_kept", 64'(line_cnt), 64'd2);

    // New frame, foreign data type dropped
    send_short(6'h00);
    idle(1);
    check_val("fs_line_cnt_clr", 64'(line_cnt), 64'd0);
    mark();
    send_hdr(6'h2A, 16'd32);
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h01010101 * (i + 1), 4'b1111, i == 7);
    end
    idle(2);
    check_val("dt2a_drop", 64'(drop_pulses - d_base), 64'd1);
    check_val("dt2a_groups", n_groups(), 64'd0);

    // Bad word counts
    mark();
    send_hdr(6'h2B, 16'd7);
    send_beat(32'h11111111, 4'b1111, 1'b0);
    send_beat(32'h00222222, 4'b0111, 1'b1);
    idle(2);
    check_val("wc7_err", 64'(err_pulses - e_base), 64'd1);
    check_val("wc7_groups", n_groups(), 64'd0);
    mark();
    send_hdr(6'h2B, 16'd0);
    idle(2);
    check_val("wc0_err", 64'(err_pulses - e_base), 64'd1);

    // Short line: 9 of 10 bytes before eop
    mark();
    send_hdr(6'h2B, 16'd10);
    send_beat(32'h04030201, 4'b1111, 1'b0);
    send_beat(32'h08070605, 4'b1111, 1'b0);
    send_beat(32'h00000009, 4'b0001, 1'b1);
    idle(2);
    check_val("short_groups", n_groups(), 64'd1);
    check_val("short_tdata", 64'(grp_data[g_base]), 64'(G5));
    check_val("short_tuser", 64'(grp_user[g_base]), 64'd1);
    check_val("short_tlast", 64'(grp_last[g_base]), 64'd0);
    check_val("short_err", 64'(err_pulses - e_base), 64'd1);
    check_val("short_line_cnt", 64'(line_cnt), 64'd0);

    // Clean line after the error: buffer must have been flushed
    mark();
    send_hdr(6'h2B, 16'd5);
    send_beat(32'h44332211, 4'b1111, 1'b0);
    send_beat(32'h000000E4, 4'b0001, 1'b1);
    idle(2);
    check_val("rec_tdata", 64'(grp_data[g_base]), 64'(G1));
    check_val("rec_tuser", 64'(grp_user[g_base]), 64'd0);
    check_val("rec_tlast", 64'(grp_last[g_base]), 64'd1);
    check_val("rec_line_cnt", 64'(line_cnt), 64'd1);

    // Reset mid-line after 3 bytes
    send_hdr(6'h2B, 16'd10);
    send_beat(32'h00332211, 4'b0111, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mrst_line_cnt", 64'(line_cnt), 64'd0);
    check_val("mrst_tvalid", 64'(pix_tvalid), 64'd0);
    check_val("mrst_tdata", 64'(pix_tdata), 64'd0);
    check_val("mrst_err", 64'(line_err), 64'd0);
    rst_n = 1'b1;
    mark();
    send_beat(32'h77665544, 4'b1111, 1'b0);
    send_beat(32'h00009988, 4'b0011, 1'b1);
    send_hdr(6'h2B, 16'd5);
    idle(2);
    check_val("mrst_groups", n_groups(), 64'd0);
    check_val("mrst_idle_drop", 64'(drop_pulses - d_base), 64'd1);

    // FE in the middle of a line after 6 bytes
    send_short(6'h00);
    mark();
    send_hdr(6'h2B, 16'd10);
    send_beat(32'h44332211, 4'b1111, 1'b0);
    send_beat(32'h000055E4, 4'b0011, 1'b0);
    send_short(6'h01);
    idle(2);
    check_val("fe_mid_groups", n_groups(), 64'd1);
    check_val("fe_mid_tdata", 64'(grp_data[g_base]), 64'(G1));
    check_val("fe_mid_tlast", 64'(grp_last[g_base]), 64'd0);
    check_val("fe_mid_err", 64'(err_pulses - e_base), 64'd1);
    mark();
    send_hdr(6'h2B, 16'd5);
    idle(2);
    check_val("fe_mid_idle_drop", 64'(drop_pulses - d_base), 64'd1);
    send_short(6'h00);
    mark();
    send_hdr(6'h2B, 16'd5);
    send_beat(32'h03020100, 4'b1111, 1'b0);
    send_beat(32'h00000004, 4'b0001, 1'b1);
    idle(2);
    check_val("nf_tdata", 64'(grp_data[g_base]), 64'(G_SPEC));
    check_val("nf_tuser", 64'(grp_user[g_base]), 64'd1);
    check_val("nf_tlast", 64'(grp_last[g_base]), 64'd1);
    check_val("nf_line_cnt", 64'(line_cnt), 64'd1);

    // FE on the same cycle as the eop beat: line completes, then IDLE
    mark();
    send_hdr(6'h2B, 16'd5);
    send_beat(32'h03020100, 4'b1111, 1'b0);
    payload = 32'h00000004; payload_be = 4'b0001; eop = 1'b1; payload_valid = 1'b1;
    short_valid = 1'b1; short_dt = 6'h01;
    @(negedge clk);
    payload_valid = 1'b0; eop = 1'b0; short_valid = 1'b0;
    idle(2);
    check_val("fe_eop_groups", n_groups(), 64'd1);
    check_val("fe_eop_tlast", 64'(grp_last[g_base]), 64'd1);
    check_val("fe_eop_line_cnt", 64'(line_cnt), 64'd2);
    check_val("fe_eop_err", 64'(err_pulses - e_base), 64'd0);
    mark();
    send_hdr(6'h2B, 16'd5);
    idle(2);
    check_val("fe_eop_idle_drop", 64'(drop_pulses - d_base), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csi2_raw10_depacker.md
Name: csi2_raw10_depacker

Overview:
- Sits directly downstream of the CSI-2 packet handler, in the receiver's internal byte clock domain.
- Consumes decoded short packets, long-packet headers and 32-bit payload beats.
- Unpacks RAW10 payload (5 bytes per 4 pixels) into a 40-bit, 4-pixel stream with start-of-frame (tuser) and end-of-line (tlast) markers.
- Tracks frame framing (FS/FE), drops non-RAW10 long packets, and flags malformed lines.

Parameters:
- RAW10_DT, 6'h2B, data type accepted for unpacking.
- FS_DT, 6'h00, short-packet data type for Frame Start.
- FE_DT, 6'h01, short-packet data type for Frame End.

Ports:
- clk_i  in  1  byte clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- short_pkt_valid_i  in  1  short packet strobe.
- short_pkt_data_type_i  in  6  short packet data type.
- long_pkt_header_valid_i  in  1  long header strobe.
- long_pkt_data_type_i  in  6  long packet data type.
- long_pkt_word_cnt_i  in  16  payload byte count.
- long_pkt_payload_i  in  32  payload; byte0 = [7:0] = first on wire.
- long_pkt_payload_valid_i  in  1  payload beat valid.
- long_pkt_payload_be_i  in  4  byte enables, contiguous from LSB (0001/0011/0111/1111).
- long_pkt_eop_i  in  1  last payload beat.
- pix_tdata_o  out  40  {P3,P2,P1,P0}, 10 bits each.
- pix_tvalid_o  out  1  group valid.
- pix_tuser_o  out  1  first group of frame.
- pix_tlast_o  out  1  last group of line.
- line_cnt_o  out  16  RAW10 lines completed in current frame.
- line_err_o  out  1  1-cycle pulse: malformed line.
- dropped_pkt_o  out  1  1-cycle pulse: long packet ignored.

Behaviour:
- Reset (rst_n_i=0 at posedge): all outputs 0, byte buffer empty, count=0, FSM=IDLE, sof_pending=0. Applies mid-line; the partial line is discarded silently.
- No backpressure: the upstream source cannot stall. Every completed group is emitted, and the consumer must accept it.
- FSM states:
  - IDLE: FS -> FRAME, sof_pending=1, line_cnt_o=0. Long headers in IDLE -> dropped_pkt_o pulse; their payload is ignored.
  - FRAME: long header with RAW10_DT -> LINE, latch word_cnt. Any other data type -> dropped_pkt_o pulse, stay in FRAME, ignore payload. FE -> IDLE.
  - LINE: accept payload beats. eop beat -> FRAME.
  - A second FS in FRAME restarts the frame (line_cnt_o=0, sof_pending=1).
  - FE received in LINE -> line_err_o pulse, buffer flushed, -> IDLE.
- Header check: RAW10 header with word_cnt==0 or word_cnt mod 5 != 0 -> line_err_o pulse at header, packet dropped (stay FRAME).
- Accumulator:
  - 8-byte buffer plus 4-bit count. Each valid beat appends popcount(be) bytes in wire order.
  - If count+new >= 5 in that cycle, the 5 oldest bytes form one group, registered out on the next edge (latency 1 cycle from the completing beat). Remaining bytes shift down.
  - Max occupancy is 8; overflow is impossible because inflow is at most 4 bytes/cycle and outflow is 5 bytes/cycle.
- Pixel math: for group bytes b0..b4, Pi = {bi, b4[2i+1:2i]}, i=0..3.
- pix_tuser_o = sof_pending on the first group emitted after FS; sof_pending then clears.
- pix_tlast_o = 1 on the group consuming the eop beat's last byte; line_cnt_o increments the same cycle.
- eop with leftover bytes (count != 0 after extraction) -> line_err_o pulse, leftover discarded, no tlast, line_cnt_o unchanged.
- Simultaneous short packet and payload beat: the payload is processed first, then the state transition. An FE arriving on the same cycle as the eop beat completes the line normally, then -> IDLE.
- line_cnt_o wraps at 16'hFFFF -> 0.

Test Plan:
- FS, RAW10 header wc=5, beats 0x03020100/1111 then 0x00000004/0001+eop -> one group tdata=40'h03_0080_1400, tuser=1, tlast=1, line_cnt_o=1.
- Same frame, second line wc=20 (five full beats of 4 bytes) -> 4 groups on consecutive-eligible cycles, tuser=0 on all, tlast only on the 4th, line_cnt_o=2; then FE -> IDLE.
- Long header with DT=0x2A in FRAME, 8 payload beats -> dropped_pkt_o single pulse, zero pix_tvalid_o.
- RAW10 header wc=7 -> line_err_o pulse at header, no output groups; wc=10 whose eop beat has be=0001 (9 bytes delivered) -> one group, then line_err_o, no tlast.
- rst_n_i low for 1 cycle mid-line after 3 bytes -> all outputs 0, FSM IDLE; subsequent payload ignored until FS.
- FE during LINE after 6 bytes -> one group already emitted, line_err_o pulse, FSM IDLE, next FS frame starts with tuser=1.
